// File: rtl/stack_pkg.sv
// Shared opcode/error encodings and the per-opcode depth table for the operand stack.
package stack_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_DEPTH = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_PUSH = 4'h1,
        OP_POP  = 4'h2,
        OP_DUP  = 4'h3,
        OP_SWAP = 4'h4,
        OP_OVER = 4'h5,
        OP_ADD  = 4'h6,
        OP_SUB  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOT  = 4'hB
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNDERFLOW = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_ILLEGAL   = 2'd3
    } err_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

    // Minimum depth each opcode needs; illegal slots are don't-care (0).
    localparam logic [1:0] OP_NEED [16] = '{
        2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0
    };

    // Depth change of each opcode when it executes.
    localparam logic signed [1:0] OP_NET [16] = '{
        2'sd0, 2'sd1, -2'sd1, 2'sd1, 2'sd0, 2'sd1, -2'sd1, -2'sd1,
        -2'sd1, -2'sd1, -2'sd1, 2'sd0, 2'sd0, 2'sd0, 2'sd0, 2'sd0
    };

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'hB);
    endfunction

endpackage

// File: rtl/stack_core_alu.sv
// Combinational ALU for the stack: computes N op T and the carry/borrow for ADD/SUB.
module stack_alu
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] n,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             writes_carry
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Extended add/sub so the top bit is the carry (ADD) or borrow (SUB)
    always_comb begin
        sum_s  = {1'b0, n} + {1'b0, t};
        diff_s = {1'b0, n} - {1'b0, t};
    end

    // Operation select
    always_comb begin
        result       = t;
        carry_out    = 1'b0;
        writes_carry = 1'b0;
        case (op)
            OP_ADD: begin
                result       = sum_s[WIDTH-1:0];
                carry_out    = sum_s[WIDTH];
                writes_carry = 1'b1;
            end
            OP_SUB: begin
                result       = diff_s[WIDTH-1:0];
                carry_out    = diff_s[WIDTH];
                writes_carry = 1'b1;
            end
            OP_AND:  result = n & t;
            OP_OR:   result = n | t;
            OP_XOR:  result = n ^ t;
            OP_NOT:  result = ~t;
            default: result = t;
        endcase
    end

endmodule

// File: rtl/stack_core.sv
// Operand stack: register-array storage with a depth pointer, single-cycle ops,
// and a sticky error that halts acceptance until clear_err.
module stack_core
    import stack_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_imm,
    input  logic             clear_err,
    output logic [WIDTH-1:0] top_data,
    output logic [WIDTH-1:0] next_data,
    output logic [DW-1:0]    depth,
    output logic             empty,
    output logic             full,
    output logic             carry,
    output logic             err,
    output logic [1:0]       err_code
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [DW-1:0] ONE_D     = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] TWO_D     = ONE_D + ONE_D;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    logic [WIDTH-1:0] stack_r [DEPTH];
    logic [DW-1:0]    depth_r;
    logic             carry_r;
    run_state_t       state_r;
    run_state_t       state_nxt_s;
    err_t             err_code_r;
    err_t             err_code_nxt_s;

    logic [PW-1:0]    top_idx_s;
    logic [PW-1:0]    next_idx_s;
    logic [PW-1:0]    push_idx_s;
    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] next_s;
    logic             empty_s;
    logic             full_s;
    logic [1:0]       need_s;
    logic signed [1:0] net_s;
    logic             fire_s;
    logic             exec_s;
    err_t             fault_s;
    logic [DW-1:0]    depth_nxt_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_carry_s;
    logic             alu_writes_carry_s;

    // Read ports; entries at or above depth are masked to zero
    always_comb begin
        top_idx_s  = PW'(depth_r - ONE_D);
        next_idx_s = PW'(depth_r - TWO_D);
        push_idx_s = PW'(depth_r);
        empty_s    = (depth_r == {DW{1'b0}});
        full_s     = (depth_r == DEPTH_MAX);
        if (!empty_s) begin
            top_s = stack_r[top_idx_s];
        end else begin
            top_s = {WIDTH{1'b0}};
        end
        if (depth_r >= TWO_D) begin
            next_s = stack_r[next_idx_s];
        end else begin
            next_s = {WIDTH{1'b0}};
        end
    end

    // Operation legality check; priority illegal > underflow > overflow
    always_comb begin
        need_s  = OP_NEED[op_code];
        net_s   = OP_NET[op_code];
        fire_s  = op_valid && (state_r == ST_RUN);
        fault_s = ERR_NONE;
        if (!op_legal(op_code)) begin
            fault_s = ERR_ILLEGAL;
        end else if (depth_r < {{(DW-2){1'b0}}, need_s}) begin
            fault_s = ERR_UNDERFLOW;
        end else if ((net_s == 2'sd1) && full_s) begin
            fault_s = ERR_OVERFLOW;
        end else begin
            fault_s = ERR_NONE;
        end
        exec_s = fire_s && (fault_s == ERR_NONE);
        if (net_s == 2'sd1) begin
            depth_nxt_s = depth_r + ONE_D;
        end else if (net_s == -2'sd1) begin
            depth_nxt_s = depth_r - ONE_D;
        end else begin
            depth_nxt_s = depth_r;
        end
    end

    stack_alu #(.WIDTH(WIDTH)) u_alu (
        .op           (op_code),
        .n            (next_s),
        .t            (top_s),
        .result       (alu_result_s),
        .carry_out    (alu_carry_s),
        .writes_carry (alu_writes_carry_s)
    );

    // Stack storage, depth pointer and carry flag
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stack_r[i] <= {WIDTH{1'b0}};
            end
            depth_r <= {DW{1'b0}};
            carry_r <= 1'b0;
        end else if (exec_s) begin
            depth_r <= depth_nxt_s;
            if (alu_writes_carry_s) begin
                carry_r <= alu_carry_s;
            end
            case (op_code)
                OP_PUSH: stack_r[push_idx_s] <= op_imm;
                OP_DUP:  stack_r[push_idx_s] <= top_s;
                OP_OVER: stack_r[push_idx_s] <= next_s;
                OP_SWAP: begin
                    stack_r[top_idx_s]  <= next_s;
                    stack_r[next_idx_s] <= top_s;
                end
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:
                    stack_r[next_idx_s] <= alu_result_s;
                OP_NOT:  stack_r[top_idx_s] <= alu_result_s;
                default: ;
            endcase
        end
    end

    // Run/halt state and latched error cause
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_RUN;
            err_code_r <= ERR_NONE;
        end else begin
            state_r    <= state_nxt_s;
            err_code_r <= err_code_nxt_s;
        end
    end

    // Halt on a faulting op; resume on clear_err with the stack intact
    always_comb begin
        state_nxt_s    = state_r;
        err_code_nxt_s = err_code_r;
        case (state_r)
            ST_RUN: begin
                if (fire_s && (fault_s != ERR_NONE)) begin
                    state_nxt_s    = ST_HALT;
                    err_code_nxt_s = fault_s;
                end else begin
                    state_nxt_s    = ST_RUN;
                    err_code_nxt_s = err_code_r;
                end
            end
            ST_HALT: begin
                if (clear_err) begin
                    state_nxt_s    = ST_RUN;
                    err_code_nxt_s = ERR_NONE;
                end else begin
                    state_nxt_s    = ST_HALT;
                    err_code_nxt_s = err_code_r;
                end
            end
            default: begin
                state_nxt_s    = ST_RUN;
                err_code_nxt_s = ERR_NONE;
            end
        endcase
    end

    assign err       = (state_r == ST_HALT);
    assign op_ready  = !err;
    assign err_code  = err_code_r;
    assign top_data  = top_s;
    assign next_data = next_s;
    assign depth     = depth_r;
    assign empty     = empty_s;
    assign full      = full_s;
    assign carry     = carry_r;

endmodule

// File: tb/tb_stack_core.sv
// Randomized and directed checks of stack_core against a queue-based reference model.
module tb_stack_core;

    localparam int W  = 8;
    localparam int D  = 8;
    localparam int DW = 4;

    logic          clock;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_code;
    logic [W-1:0]  op_imm;
    logic          clear_err;
    logic [W-1:0]  top_data;
    logic [W-1:0]  next_data;
    logic [DW-1:0] depth;
    logic          empty;
    logic          full;
    logic          carry;
    logic          err;
    logic [1:0]    err_code;

    stack_core #(.WIDTH(W), .DEPTH(D)) dut (
        .clock     (clock),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .op_imm    (op_imm),
        .clear_err (clear_err),
        .top_data  (top_data),
        .next_data (next_data),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .carry     (carry),
        .err       (err),
        .err_code  (err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    bit         m_carry;
    bit         m_err;
    logic [1:0] m_code;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit vld, input logic [3:0] code,
                              input logic [7:0] imm, input bit clr);
        int need;
        bit grows;
        int sz;
        int t;
        int n;
        int r;
        if (rst) begin
            mq.delete();
            m_carry = 1'b0;
            m_err   = 1'b0;
            m_code  = 2'd0;
        end else if (m_err) begin
            if (clr) begin
                m_err  = 1'b0;
                m_code = 2'd0;
            end
        end else if (vld) begin
            sz = mq.size();
            grows = (code == 4'd1) || (code == 4'd3) || (code == 4'd5);
            case (code)
                4'd0, 4'd1:                         need = 0;
                4'd2, 4'd3, 4'd11:                  need = 1;
                default:                            need = 2;
            endcase
            if (code > 4'd11) begin
                m_err = 1'b1; m_code = 2'd3;
            end else if (sz < need) begin
                m_err = 1'b1; m_code = 2'd1;
            end else if (grows && sz == D) begin
                m_err = 1'b1; m_code = 2'd2;
            end else begin
                case (code)
                    4'd1: mq.push_back(imm);
                    4'd2: void'(mq.pop_back());
                    4'd3: mq.push_back(mq[sz-1]);
                    4'd4: begin
                        t = mq.pop_back(); n = mq.pop_back();
                        mq.push_back(t[7:0]); mq.push_back(n[7:0]);
                    end
                    4'd5: mq.push_back(mq[sz-2]);
                    4'd11: begin
                        t = mq.pop_back();
                        mq.push_back(~t[7:0]);
                    end
                    4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
                        t = mq.pop_back(); n = mq.pop_back();
                        case (code)
                            4'd6: begin r = n + t; m_carry = (r > 255); end
                            4'd7: begin r = n - t; m_carry = (n < t); end
                            4'd8: r = n & t;
                            4'd9: r = n | t;
                            default: r = n ^ t;
                        endcase
                        mq.push_back(r[7:0]);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        check_eq("top_data", top_data, (sz > 0) ? mq[sz-1] : 8'h00);
        check_eq("next_data", next_data, (sz > 1) ? mq[sz-2] : 8'h00);
        check_eq("depth", depth, sz);
        check_eq("empty", empty, (sz == 0) ? 1 : 0);
        check_eq("full", full, (sz == D) ? 1 : 0);
        check_eq("carry", carry, m_carry);
        check_eq("err", err, m_err);
        check_eq("err_code", err_code, m_code);
    endtask

    // Called at a negedge; drives inputs, clocks once, checks at the next negedge.
    task automatic cycle(input bit rst, input bit vld, input logic [3:0] code,
                         input logic [7:0] imm, input bit clr);
        reset     = rst;
        op_valid  = vld;
        op_code   = code;
        op_imm    = imm;
        clear_err = clr;
        check_eq("op_ready", op_ready, m_err ? 0 : 1);
        @(posedge clock);
        model_step(rst, vld, code, imm, clr);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic op(input logic [3:0] code, input logic [7:0] imm);
        cycle(1'b0, 1'b1, code, imm, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    endtask

    initial begin
        bit       rst;
        bit       vld;
        bit       clr;
        int       r;
        logic [3:0] code;
        reset = 1'b1; op_valid = 1'b0; op_code = 4'd0; op_imm = 8'h00; clear_err = 1'b0;
        mq.delete(); m_carry = 1'b0; m_err = 1'b0; m_code = 2'd0;
        @(negedge clock);
        do_reset();
        do_reset();
        check_eq("reset_empty", empty, 1);

        // add, carry and borrow
        op(4'd1, 8'h05); op(4'd1, 8'h03); op(4'd6, 8'h00);
        check_eq("plan_add_top", top_data, 8'h08);
        check_eq("plan_add_carry", carry, 0);
        op(4'd1, 8'hF0); op(4'd1, 8'h20); op(4'd6, 8'h00);
        check_eq("plan_add_wrap", top_data, 8'h10);
        check_eq("plan_add_c1", carry, 1);
        op(4'd1, 8'h20); op(4'd7, 8'h00);
        check_eq("plan_sub_top", top_data, 8'hF0);
        check_eq("plan_sub_borrow", carry, 1);

        // fill to full, then overflow
        do_reset();
        for (int i = 1; i <= 8; i++) op(4'd1, 8'(i));
        check_eq("plan_full", full, 1);
        check_eq("plan_full_next", next_data, 8'h07);
        op(4'd1, 8'h99);
        check_eq("plan_ovf_code", err_code, 2);
        check_eq("plan_ovf_top", top_data, 8'h08);
        do_clear();
        check_eq("plan_clr_depth", depth, 8);

        // underflow, ops ignored while halted
        do_reset();
        op(4'd2, 8'h00);
        check_eq("plan_unf_code", err_code, 1);
        for (int i = 0; i < 3; i++) op(4'd1, 8'h55);
        check_eq("plan_halt_depth", depth, 0);
        do_clear();
        op(4'd1, 8'hAA);
        check_eq("plan_push_aa", top_data, 8'hAA);

        // swap / over / not / illegal
        do_reset();
        op(4'd1, 8'h12); op(4'd1, 8'h34); op(4'd4, 8'h00);
        check_eq("plan_swap_top", top_data, 8'h12);
        check_eq("plan_swap_next", next_data, 8'h34);
        op(4'd5, 8'h00);
        check_eq("plan_over_top", top_data, 8'h34);
        op(4'd11, 8'h00);
        check_eq("plan_not_top", top_data, 8'hCB);
        op(4'hE, 8'h00);
        check_eq("plan_illegal_code", err_code, 3);
        check_eq("plan_illegal_depth", depth, 3);

        // reset while halted with depth 5
        op(4'd0, 8'h00);
        do_reset();
        for (int i = 0; i < 5; i++) op(4'd1, 8'(8'h40 + i));
        op(4'hC, 8'h00);
        do_reset();
        check_eq("plan_rst_depth", depth, 0);
        check_eq("plan_rst_err", err, 0);

        // randomized traffic with gaps, clears and occasional resets
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            vld = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 30) code = 4'd1;
            else if (r < 33) code = 4'(12 + $urandom_range(0, 3));
            else code = 4'($urandom_range(0, 11));
            clr = m_err ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            cycle(rst, vld, code, 8'($urandom), clr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
